irq_controller: RTL

- Interrupt-side counterpart of the CSR trap interface.
- Collects level-sensitive device requests and masks them with the machine interrupt-enable register.
- Selects one request by fixed priority and issues a one-cycle trap pulse plus mcause value to the core and the CSR block.
- Tracks the handler until mret, then returns a one-hot acknowledge to the serviced device. No nesting.

---
 rtl/irq_controller.sv | 87 ++++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: fixed-priority, non-nesting interrupt controller.
// Masks level requests with mie, issues a one-cycle trap plus mcause,
// then waits for mret and sends a one-hot acknowledge to the device.
module irq_controller #(
   parameter int          IRQ_NUM    = 16,
   parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IRQ_NUM-1:0] irq_req_i,
   input  logic [31:0]        mie_i,
   input  logic               exception_i,
   input  logic               mret_i,
   input  logic               stall_i,
   output logic               irq_o,
   output logic [31:0]        irq_cause_o,
   output logic [IRQ_NUM-1:0] irq_ret_o,
   output logic               busy_o
);

   typedef enum logic [1:0] {IDLE, TRAP, SERVICE, RET} state_e;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        exc_h_q, exc_h_d;

   // Requests are zero-extended to the full mie width; lines above
   // IRQ_NUM never assert, so the upper mie bits cannot matter.
   logic [31:0] pend;
   logic        any_pend;
   logic [3:0]  winner;
   logic        take;

   assign pend     = 32'(irq_req_i) & mie_i;
   assign any_pend = |pend;
   assign take     = any_pend && !stall_i && !exception_i && !exc_h_q;

   // Lowest set pending line wins.
   always_comb begin
      winner = 4'd0;
      for (int i = IRQ_NUM-1; i >= 0; i--)
         if (pend[i]) winner = i[3:0];
   end

   // State, captured index and exception-handler flag registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         exc_h_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exc_h_q <= exc_h_d;
      end
   end

   // Next state; exception in the same cycle as mret always wins.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      exc_h_d = exc_h_q;
      if (exception_i)  exc_h_d = 1'b1;
      else if (mret_i)  exc_h_d = 1'b0;
      case (state_q)
         IDLE: if (take) begin
            state_d = TRAP;
            idx_d   = winner;
         end
         TRAP:    state_d = SERVICE;
         SERVICE: if (mret_i && !exc_h_q && !exception_i) state_d = RET;
         RET:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registers only; cause is held from TRAP to RET.
   always_comb begin
      irq_o       = (state_q == TRAP);
      busy_o      = (state_q != IDLE);
      irq_cause_o = (state_q == IDLE) ? 32'd0 : CAUSE_BASE + {28'd0, idx_q};
      irq_ret_o   = '0;
      for (int i = 0; i < IRQ_NUM; i++)
         irq_ret_o[i] = (state_q == RET) && (idx_q == i[3:0]);
   end

endmodule
